packet_issue_ctrl: RTL

//  Sequencer for the packet program memory. Walks addresses 0..PKT_LEN-1 and registers each 38-bit packet.

---
 rtl/packet_issue_ctrl_if.sv | 27 ++
 rtl/packet_issue_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/packet_issue_ctrl_if.sv
// rtl/packet_issue_ctrl_if.sv - program-memory fetch and ring-injection signal bundle
interface packet_issue_ctrl_if #(
  parameter int PKT_W  = 38,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] fetch_addr;
  logic [PKT_W-1:0]  fetch_data;
  logic [PKT_W-1:0]  pkt_out;
  logic              pkt_valid;
  logic              pkt_ready;

  modport master (
    output fetch_addr,
    output pkt_out,
    output pkt_valid,
    input  fetch_data,
    input  pkt_ready
  );

  modport slave (
    input  fetch_addr,
    input  pkt_out,
    input  pkt_valid,
    output fetch_data,
    output pkt_ready
  );
endinterface

// File: rtl/packet_issue_ctrl.sv
// rtl/packet_issue_ctrl.sv - walks the packet program and issues live packets to the ring
// Define ISSUE_STALL_CNT_EN to add the o_stall_cnt ready-stall counter output.
module packet_issue_ctrl #(
  parameter int         PKT_W      = 38,
  parameter int         ADDR_W     = 5,
  parameter logic [2:0] HDR_MARK   = 3'b111,
  parameter int         GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [ADDR_W:0]     i_pkt_len,
  packet_issue_ctrl_if.master bus,
  output logic                o_busy,
  output logic                o_done,
`ifdef ISSUE_STALL_CNT_EN
  output logic [ADDR_W:0]     o_issue_cnt,
  output logic [15:0]         o_stall_cnt
`else
  output logic [ADDR_W:0]     o_issue_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_FIN} state_t;

  localparam logic [ADDR_W:0] LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      GAP_LOAD = 8'(GAP_CYCLES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [PKT_W-1:0]  r_pkt_out;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W:0]   r_len_q;
  logic [7:0]        r_gap_cnt;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_hdr_live;
  logic              w_at_end;

  assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_accept   = (r_state == S_ISSUE) && bus.pkt_ready;
  assign w_hdr_live = (bus.fetch_data[PKT_W-1 -: 3] == HDR_MARK);
  // The accepted count equals the address within a run, but keeps counting past the saturated address.
  assign w_at_end   = (r_issue_cnt >= r_len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_FETCH;
        S_FETCH: w_state_nxt = (w_at_end || !w_hdr_live) ? S_FIN : S_ISSUE;
        S_ISSUE: if (bus.pkt_ready) w_state_nxt = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
        S_GAP:   if (r_gap_cnt <= 8'd1) w_state_nxt = S_FETCH;
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_addr <= '0;
      r_pkt_out    <= '0;
      r_issue_cnt  <= '0;
      r_len_q      <= '0;
      r_gap_cnt    <= '0;
    end else begin
      if (w_start_ok) begin
        r_len_q      <= (i_pkt_len > LEN_MAX) ? LEN_MAX : i_pkt_len;
        r_fetch_addr <= '0;
        r_issue_cnt  <= '0;
      end
      if ((r_state == S_FETCH) && (w_state_nxt == S_ISSUE)) begin
        r_pkt_out <= bus.fetch_data;
      end
      // A handshake coinciding with abort still counts.
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        if (r_fetch_addr != {ADDR_W{1'b1}}) r_fetch_addr <= r_fetch_addr + 1'b1;
        r_gap_cnt   <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ISSUE) && !bus.pkt_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign bus.fetch_addr = r_fetch_addr;
  assign bus.pkt_out    = r_pkt_out;
  assign bus.pkt_valid  = (r_state == S_ISSUE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_FIN);
  assign o_issue_cnt    = r_issue_cnt;

endmodule
